multi_encoder_pwm: RTL and testbench



---
 rtl/multi_encoder_pwm_pkg.sv | 23 ++
 rtl/multi_encoder_pwm_channel.sv | 83 ++++++++
 rtl/multi_encoder_pwm.sv | 82 ++++++++
 tb/tb_multi_encoder_pwm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_encoder_pwm_pkg.sv
// Shared definitions for the multi-channel encoder/PWM block: value update
// mode encoding and saturating arithmetic helpers.
package multi_encoder_pwm_pkg;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] step,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] val,
                                          input logic [31:0] step);
    return (val < step) ? '0 : val - step;
  endfunction

endpackage

// File: rtl/multi_encoder_pwm_channel.sv
// One encoder channel: 2-flop sync, tick-gated debounce, x4 quadrature decode,
// and the duty value register with host load override.
module encoder_channel
  import multi_encoder_pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int DB_COUNT = 4,
  parameter int INIT_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             tick,
  input  logic             mode_wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // bit 0 carries the A line, bit 1 the B line
  logic [1:0]         s1, s2, deb, prev;
  logic [1:0][CW-1:0] cnt;
  logic               step_ev, up;
  logic [WIDTH-1:0]   stepped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      deb  <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      s1   <= {enc_b, enc_a};
      s2   <= s1;
      prev <= deb;
      for (int unsigned k = 0; k < 2; k++) begin
        if (s2[k] == deb[k]) begin
          cnt[k] <= '0;
        end else if (tick) begin
          if (cnt[k] == CNT_LAST) begin
            deb[k] <= s2[k];
            cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + CW'(1);
          end
        end
      end
    end
  end

  // A simultaneous change on both lines cancels in the XOR and is dropped
  assign step_ev = (deb[0] ^ prev[0]) ^ (deb[1] ^ prev[1]);
  assign up      = deb[0] ^ prev[1];

  always_comb begin
    stepped = value;
    if (mode_e'(mode_wrap) == MODE_WRAP) begin
      stepped = up ? value + WIDTH'(STEP) : value - WIDTH'(STEP);
    end else if (up) begin
      stepped = WIDTH'(sat_add(32'(value), 32'(STEP), 32'(MAX_VAL)));
    end else begin
      stepped = WIDTH'(sat_sub(32'(value), 32'(STEP)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= WIDTH'(INIT_VAL);
    end else if (load) begin
      value <= load_val;
    end else if (step_ev) begin
      value <= stepped;
    end
  end

endmodule

// File: rtl/multi_encoder_pwm.sv
// N-channel encoder-to-PWM block: shared debounce prescaler and PWM counter,
// per-channel shadowed duty registers so updates only land on period wrap.
module multi_encoder_pwm
  import multi_encoder_pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int DB_DIV   = 1,
  parameter int DB_COUNT = 4,
  parameter int INIT_VAL = 0
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [CHANNELS-1:0]                               enc_a,
  input  logic [CHANNELS-1:0]                               enc_b,
  input  logic                                              mode_wrap,
  input  logic                                              load_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_sel,
  input  logic [WIDTH-1:0]                                  load_val,
  output logic [CHANNELS*WIDTH-1:0]                         value_o,
  output logic [CHANNELS-1:0]                               pwm_o
);

  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

  logic [PW-1:0]                presc;
  logic                         tick;
  logic [WIDTH-1:0]             pwm_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_val;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow;

  assign tick = (presc == PW'(DB_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    encoder_channel #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .DB_COUNT (DB_COUNT),
      .INIT_VAL (INIT_VAL)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enc_a     (enc_a[i]),
      .enc_b     (enc_b[i]),
      .tick      (tick),
      .mode_wrap (mode_wrap),
      .load      (load_en && (load_sel == SW'(i))),
      .load_val  (load_val),
      .value     (ch_val[i])
    );
  end

  assign value_o = ch_val;

  // Shadows refresh on the last count so each period uses one stable duty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      shadow  <= {CHANNELS{WIDTH'(INIT_VAL)}};
      pwm_o   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      if (pwm_cnt == '1) begin
        shadow <= ch_val;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pwm_o[i] <= (pwm_cnt < shadow[i]);
      end
    end
  end

endmodule

// File: tb/tb_multi_encoder_pwm.sv
// Scoreboard bench for multi_encoder_pwm: stimulus pushes expected value_o
// snapshots with due cycles; a negedge monitor checks values and PWM periods.
module tb_multi_encoder_pwm;

  localparam int C   = 3;
  localparam int W   = 8;
  localparam int PER = 256;
  localparam int LAT = 7;

  typedef struct {
    int          due;
    logic [23:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  enc_a = '0, enc_b = '0, enc_a2 = '0, enc_b2 = '0;
  logic        mode_wrap = 1'b0;
  logic        load_en = 1'b0, load_en2 = 1'b0;
  logic [1:0]  load_sel = '0, load_sel2 = '0;
  logic [7:0]  load_val = '0, load_val2 = '0;
  logic [23:0] value_o, value2;
  logic [2:0]  pwm_o, pwm2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int trk_prints = 0;
  exp_t q[$];
  int mval[C];
  int ph[C];
  logic [23:0] exp_now = '0;
  int hi[C], bad[C], cur_snap[C], next_snap[C];

  always #5 clk = ~clk;

  multi_encoder_pwm #(
    .CHANNELS(3), .WIDTH(8), .STEP(1), .DB_DIV(1), .DB_COUNT(4), .INIT_VAL(0)
  ) u_dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .mode_wrap(mode_wrap), .load_en(load_en), .load_sel(load_sel),
    .load_val(load_val), .value_o(value_o), .pwm_o(pwm_o)
  );

  multi_encoder_pwm #(
    .CHANNELS(3), .WIDTH(8), .STEP(1), .DB_DIV(4), .DB_COUNT(2), .INIT_VAL(0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enc_a(enc_a2), .enc_b(enc_b2),
    .mode_wrap(mode_wrap), .load_en(load_en2), .load_sel(load_sel2),
    .load_val(load_val2), .value_o(value2), .pwm_o(pwm2)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int model_step(int v, bit up, bit wrap);
    int r;
    if (up) r = v + 1;
    else    r = v - 1;
    if (wrap) return (r + PER) % PER;
    if (r > PER - 1) return PER - 1;
    if (r < 0) return 0;
    return r;
  endfunction

  function automatic logic [23:0] pack_model();
    logic [23:0] v;
    v = '0;
    for (int c = 0; c < C; c++) v[c*W +: W] = W'(mval[c]);
    return v;
  endfunction

  task automatic push_exp(int due);
    if (q.size() > 0 && q[$].due == due) q[$].val = pack_model();
    else q.push_back('{due: due, val: pack_model()});
  endtask

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one quadrature phase on channel ch (forward = A leads B)
  task automatic quad(int ch, bit fwd);
    int old;
    ph[ch] = (ph[ch] + (fwd ? 1 : 3)) % 4;
    enc_a[ch] = (ph[ch] == 1 || ph[ch] == 2);
    enc_b[ch] = (ph[ch] == 2 || ph[ch] == 3);
    old = mval[ch];
    mval[ch] = model_step(old, fwd, mode_wrap);
    if (mval[ch] != old) push_exp(cyc + LAT);
  endtask

  task automatic load(int ch, int val);
    load_sel = 2'(ch);
    load_val = 8'(val);
    load_en  = 1'b1;
    if (ch < C && mval[ch] != val) begin
      mval[ch] = val;
      push_exp(cyc + 1);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_now = '0;
      for (int c = 0; c < C; c++) begin
        hi[c] = 0; bad[c] = 0; cur_snap[c] = 0; next_snap[c] = 0;
      end
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (value_o !== e.val) begin
          fails++;
          $display("FAIL value_at_due: cyc %0d got %h expected %h", cyc, value_o, e.val);
        end
        exp_now = e.val;
      end
      tests++;
      if (value_o !== exp_now) begin
        fails++;
        if (trk_prints < 20)
          $display("FAIL value_track: cyc %0d got %h expected %h", cyc, value_o, exp_now);
        trk_prints++;
      end
      if (cyc >= 1) begin
        int p;
        p = (cyc - 1) % PER;
        for (int c = 0; c < C; c++) begin
          if (pwm_o[c] !== (p < cur_snap[c])) bad[c]++;
          if (pwm_o[c] === 1'b1) hi[c]++;
        end
        if (p == PER - 1) begin
          for (int c = 0; c < C; c++) begin
            tests++;
            if (hi[c] != cur_snap[c] || bad[c] != 0) begin
              fails++;
              $display("FAIL pwm_period ch%0d: cyc %0d high %0d expected %0d, misplaced %0d",
                       c, cyc, hi[c], cur_snap[c], bad[c]);
            end
            hi[c] = 0;
            bad[c] = 0;
            cur_snap[c] = next_snap[c];
          end
        end
      end
      if (cyc % PER == PER - 1)
        for (int c = 0; c < C; c++) next_snap[c] = int'(exp_now[c*W +: W]);
    end
  end

  initial begin
    for (int c = 0; c < C; c++) begin mval[c] = 0; ph[c] = 0; end
    wait_cyc(3);
    check("reset_value", int'(value_o), 0);
    check("reset_pwm", int'(pwm_o), 0);
    @(negedge clk); #2 reset = 1'b0;

    // Idle: nothing moves
    wait_cyc(600);
    check("idle_value", int'(value_o), 0);

    // Forward then reverse on ch1
    for (int i = 0; i < 4; i++) begin quad(1, 1'b1); wait_cyc(20); end
    check("ch1_fwd4", int'(value_o[15:8]), 4);
    for (int i = 0; i < 4; i++) begin quad(1, 1'b0); wait_cyc(20); end
    check("ch1_rev4", int'(value_o[15:8]), 0);
    check("others_after_ch1", int'({value_o[23:16], value_o[7:0]}), 0);

    // Glitch rejection
    enc_a[0] = 1'b1; wait_cyc(2); enc_a[0] = 1'b0; wait_cyc(20);
    check("glitch2_ch0", int'(value_o[7:0]), 0);
    while (cyc % 4 != 2) @(negedge clk);
    enc_a2[0] = 1'b1; wait_cyc(6); enc_a2[0] = 1'b0; wait_cyc(20);
    check("div4_glitch6", int'(value2[7:0]), 0);
    enc_a2[0] = 1'b1; wait_cyc(20);
    check("div4_level_up", int'(value2[7:0]), 1);
    enc_a2[0] = 1'b0; wait_cyc(20);
    check("div4_level_down", int'(value2[7:0]), 0);

    // Saturate / wrap boundaries on ch2
    load(2, 255); wait_cyc(5);
    check("load255_ch2", int'(value_o[23:16]), 255);
    mode_wrap = 1'b0; quad(2, 1'b1); wait_cyc(20);
    check("sat_up_255", int'(value_o[23:16]), 255);
    mode_wrap = 1'b1; quad(2, 1'b1); wait_cyc(20);
    check("wrap_up_255", int'(value_o[23:16]), 0);
    load(2, 0); mode_wrap = 1'b0; quad(2, 1'b0); wait_cyc(20);
    check("sat_down_0", int'(value_o[23:16]), 0);
    mode_wrap = 1'b1; quad(2, 1'b0); wait_cyc(20);
    check("wrap_down_0", int'(value_o[23:16]), 255);
    mode_wrap = 1'b0;

    // PWM duty: mid-period loads take effect only after the wrap
    while (cyc % PER != 100) @(negedge clk);
    load(0, 64); wait_cyc(600);
    load(0, 0); wait_cyc(600);
    load(0, 255); wait_cyc(600);
    load(0, 0); wait_cyc(20);

    // Load collides with encoder edges
    quad(0, 1'b1); quad(1, 1'b1);
    wait_cyc(LAT - 1);
    load(1, 8'h5A); wait_cyc(20);
    check("collide_ch0_step", int'(value_o[7:0]), 1);
    check("collide_ch1_load", int'(value_o[15:8]), 8'h5A);
    load(3, 8'hAA); wait_cyc(5);
    check("load_sel_oob", int'(value_o), int'(pack_model()));

    // Reset in the middle of a debounce and a PWM period
    while (cyc % PER != 20) @(negedge clk);
    quad(0, 1'b1); wait_cyc(3);
    #2 reset = 1'b1;
    #1;
    check("midreset_value", int'(value_o), 0);
    check("midreset_pwm", int'(pwm_o), 0);
    enc_a = '0; enc_b = '0;
    for (int c = 0; c < C; c++) begin mval[c] = 0; ph[c] = 0; end
    wait_cyc(4);
    @(negedge clk); #2 reset = 1'b0;
    wait_cyc(300);
    check("post_reset_value", int'(value_o), 0);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
